// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: opcode/memory handshake and datapath control bundle
// between the multi-cycle LEGv8 controller and its datapath.
interface multicycle_ctrl_if;
   logic [10:0] Op;
   logic        mem_ready;
   logic        mem_req;
   logic        IRWrite;
   logic        PCWrite;
   logic        Reg2Loc;
   logic        ALUSrc;
   logic        MemtoReg;
   logic        RegWrite;
   logic        MemRead;
   logic        MemWrite;
   logic        Branch;
   logic [1:0]  ALUOp;
   logic        illegal_op;
   logic        bus_err;
   logic [3:0]  state;

   modport master (
      input  Op, mem_ready,
      output mem_req, IRWrite, PCWrite, Reg2Loc, ALUSrc, MemtoReg,
      output RegWrite, MemRead, MemWrite, Branch, ALUOp,
      output illegal_op, bus_err, state
   );

   modport slave (
      output Op, mem_ready,
      input  mem_req, IRWrite, PCWrite, Reg2Loc, ALUSrc, MemtoReg,
      input  RegWrite, MemRead, MemWrite, Branch, ALUOp,
      input  illegal_op, bus_err, state
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore FSM sequencing LEGv8 instructions with memory timeout.
// Optional MULTICYCLE_TRAP_EN: illegal opcodes park in TRAP instead of NOP.
module multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 15
) (
   input logic              clk,
   input logic              reset_n,
   multicycle_ctrl_if.master bus
);
   localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TMAX = CW'(MEM_TIMEOUT);

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_FETCH    = 4'd1;
   localparam logic [3:0] S_DECODE   = 4'd2;
   localparam logic [3:0] S_MEM_ADDR = 4'd3;
   localparam logic [3:0] S_MEM_RD   = 4'd4;
   localparam logic [3:0] S_WB_MEM   = 4'd5;
   localparam logic [3:0] S_MEM_WR   = 4'd6;
   localparam logic [3:0] S_EXEC_R   = 4'd7;
   localparam logic [3:0] S_WB_ALU   = 4'd8;
   localparam logic [3:0] S_BRANCH   = 4'd9;
   localparam logic [3:0] S_TRAP     = 4'd10;

   localparam logic [2:0] C_LD  = 3'd0;
   localparam logic [2:0] C_ST  = 3'd1;
   localparam logic [2:0] C_CB  = 3'd2;
   localparam logic [2:0] C_R   = 3'd3;
   localparam logic [2:0] C_ILL = 3'd4;

   logic [3:0]    state_q, state_d;
   logic [2:0]    cls_q, cls_d, dec_cls;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ill_q, ill_d;
   logic          err_q, err_d;
   logic          mem_st, tmo;

   // Opcode class decode from the instruction register
   always_comb begin
      dec_cls = C_ILL;
      unique case (1'b1)
         bus.Op == 11'b111_1100_0010: dec_cls = C_LD;
         bus.Op == 11'b111_1100_0000: dec_cls = C_ST;
         bus.Op[10:3] == 8'b1011_0100: dec_cls = C_CB;
         bus.Op == 11'b100_0101_1000: dec_cls = C_R;
         bus.Op == 11'b110_0101_1000: dec_cls = C_R;
         bus.Op == 11'b100_0101_0000: dec_cls = C_R;
         bus.Op == 11'b101_0101_0000: dec_cls = C_R;
         default:                      dec_cls = C_ILL;
      endcase
   end

   assign mem_st = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                   (state_q == S_MEM_WR);
   assign tmo = (MEM_TIMEOUT != 0) && mem_st && !bus.mem_ready &&
                (cnt_q == TMAX);

   // Next state, latched class, sticky illegal flag and wait counter
   always_comb begin
      state_d = state_q;
      cls_d   = cls_q;
      ill_d   = ill_q;
      case (state_q)
         S_IDLE:   state_d = S_FETCH;
         S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            cls_d = dec_cls;
            case (dec_cls)
               C_LD, C_ST: state_d = S_MEM_ADDR;
               C_CB:       state_d = S_BRANCH;
               C_R:        state_d = S_EXEC_R;
               default: begin
                  ill_d = 1'b1;
`ifdef MULTICYCLE_TRAP_EN
                  state_d = S_TRAP;
`else
                  state_d = S_FETCH;
`endif
               end
            endcase
         end
         S_MEM_ADDR: state_d = (cls_q == C_ST) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:   if (bus.mem_ready) state_d = S_WB_MEM;
         S_WB_MEM:   state_d = S_FETCH;
         S_MEM_WR:   if (bus.mem_ready) state_d = S_FETCH;
         S_EXEC_R:   state_d = S_WB_ALU;
         S_WB_ALU:   state_d = S_FETCH;
         S_BRANCH:   state_d = S_FETCH;
         S_TRAP:     state_d = S_TRAP;
         default:    state_d = S_IDLE;
      endcase
      if (tmo) state_d = S_IDLE;
      if (state_d != state_q) cnt_d = '0;
      else if (mem_st && !bus.mem_ready) cnt_d = cnt_q + 1'b1;
      else cnt_d = cnt_q;
      err_d = tmo;
   end

   // State registers; reset parks in IDLE with flags cleared
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cls_q   <= C_ILL;
         cnt_q   <= '0;
         ill_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         cnt_q   <= cnt_d;
         ill_q   <= ill_d;
         err_q   <= err_d;
      end
   end

   // Moore outputs per state; FETCH strobes and DECODE Reg2Loc look ahead
   always_comb begin
      bus.mem_req  = 1'b0;
      bus.IRWrite  = 1'b0;
      bus.PCWrite  = 1'b0;
      bus.Reg2Loc  = 1'b0;
      bus.ALUSrc   = 1'b0;
      bus.MemtoReg = 1'b0;
      bus.RegWrite = 1'b0;
      bus.MemRead  = 1'b0;
      bus.MemWrite = 1'b0;
      bus.Branch   = 1'b0;
      bus.ALUOp    = 2'b00;
      case (state_q)
         S_FETCH: begin
            bus.mem_req = 1'b1;
            bus.IRWrite = bus.mem_ready;
            bus.PCWrite = bus.mem_ready;
         end
         S_DECODE: bus.Reg2Loc = (dec_cls == C_ST) || (dec_cls == C_CB);
         S_MEM_ADDR: begin
            bus.ALUSrc  = 1'b1;
            bus.Reg2Loc = (cls_q == C_ST);
         end
         S_MEM_RD: begin
            bus.mem_req = 1'b1;
            bus.MemRead = 1'b1;
            bus.ALUSrc  = 1'b1;
         end
         S_WB_MEM: begin
            bus.RegWrite = 1'b1;
            bus.MemtoReg = 1'b1;
         end
         S_MEM_WR: begin
            bus.mem_req  = 1'b1;
            bus.MemWrite = 1'b1;
            bus.ALUSrc   = 1'b1;
            bus.Reg2Loc  = 1'b1;
         end
         S_EXEC_R: bus.ALUOp = 2'b10;
         S_WB_ALU: begin
            bus.RegWrite = 1'b1;
            bus.ALUOp    = 2'b10;
         end
         S_BRANCH: begin
            bus.Reg2Loc = 1'b1;
            bus.Branch  = 1'b1;
            bus.ALUOp   = 2'b01;
         end
         default: ;
      endcase
   end

   assign bus.illegal_op = ill_q;
   assign bus.bus_err    = err_q;
   assign bus.state      = state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: vector table, hand sequences and a random run
// against an instruction-level reference model of the controller.
module tb_multicycle_ctrl;
   localparam int T = 15;
   localparam logic [10:0] OP_LD  = 11'b111_1100_0010;
   localparam logic [10:0] OP_ST  = 11'b111_1100_0000;
   localparam logic [10:0] OP_CB  = 11'b101_1010_0000;
   localparam logic [10:0] OP_ADD = 11'b100_0101_1000;
   localparam logic [10:0] OP_SUB = 11'b110_0101_1000;
   localparam logic [10:0] OP_AND = 11'b100_0101_0000;
   localparam logic [10:0] OP_ORR = 11'b101_0101_0000;
   localparam logic [10:0] OP_BAD = 11'b000_0000_0000;

   // ctl = {mem_req,IRWrite,PCWrite,Reg2Loc,ALUSrc,MemtoReg,
   //        RegWrite,MemRead,MemWrite,Branch,ALUOp[1:0]}
   localparam logic [11:0] K_NONE = 12'b0000_0000_0000;
   localparam logic [11:0] K_FR   = 12'b1110_0000_0000;
   localparam logic [11:0] K_FW   = 12'b1000_0000_0000;
   localparam logic [11:0] K_R2L  = 12'b0001_0000_0000;
   localparam logic [11:0] K_MAS  = 12'b0001_1000_0000;
   localparam logic [11:0] K_MAL  = 12'b0000_1000_0000;
   localparam logic [11:0] K_MRD  = 12'b1000_1001_0000;
   localparam logic [11:0] K_WBM  = 12'b0000_0110_0000;
   localparam logic [11:0] K_MWR  = 12'b1001_1000_1000;
   localparam logic [11:0] K_EXE  = 12'b0000_0000_0010;
   localparam logic [11:0] K_WBA  = 12'b0000_0010_0010;
   localparam logic [11:0] K_BR   = 12'b0001_0000_0101;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   multicycle_ctrl_if bus();
   multicycle_ctrl #(.MEM_TIMEOUT(T)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus)
   );

   logic [11:0] act_ctl;
   assign act_ctl = {bus.mem_req, bus.IRWrite, bus.PCWrite, bus.Reg2Loc,
                     bus.ALUSrc, bus.MemtoReg, bus.RegWrite, bus.MemRead,
                     bus.MemWrite, bus.Branch, bus.ALUOp};

   int errors = 0;
   int checks = 0;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step(input logic rn, input logic [10:0] op,
                       input logic rdy);
      @(negedge clk);
      reset_n = rn;
      bus.Op = op;
      bus.mem_ready = rdy;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      bus.mem_ready = 1'b0;
      #1;
      check("rst_state", 32'(bus.state), 32'd0);
      check("rst_ctl", 32'(act_ctl), 32'd0);
      check("rst_flags", {30'd0, bus.illegal_op, bus.bus_err}, 32'd0);
   endtask

   // Reference model: instruction class -> list of states to walk
   function automatic int cls_of(logic [10:0] op);
      if (op == OP_LD) return 0;
      if (op == OP_ST) return 1;
      if (op[10:3] == 8'b1011_0100) return 2;
      if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR)
         return 3;
      return 4;
   endfunction

   function automatic logic [11:0] exp_ctl(int st, logic rdy,
                                           logic [10:0] op, int lcls);
      case (st)
         1: return rdy ? K_FR : K_FW;
         2: return (cls_of(op) == 1 || cls_of(op) == 2) ? K_R2L : K_NONE;
         3: return (lcls == 1) ? K_MAS : K_MAL;
         4: return K_MRD;
         5: return K_WBM;
         6: return K_MWR;
         7: return K_EXE;
         8: return K_WBA;
         9: return K_BR;
         default: return K_NONE;
      endcase
   endfunction

   typedef struct {
      logic        rn;
      logic [10:0] op;
      logic        rdy;
      logic [3:0]  st;
      logic [11:0] ctl;
   } vec_t;

   vec_t tbl[22];

   int m_st, m_cls, m_wait, stall, nst;
   bit m_ill, m_err, nerr;
   int plan[$];
   logic [10:0] cur_op;
   logic rdy;

   initial begin
      bus.Op = OP_ADD;
      bus.mem_ready = 1'b0;

      tbl[0]  = '{1'b0, OP_ADD, 1'b1, 4'd0, K_NONE};
      tbl[1]  = '{1'b1, OP_ADD, 1'b1, 4'd0, K_NONE};
      tbl[2]  = '{1'b1, OP_ADD, 1'b1, 4'd1, K_FR};
      tbl[3]  = '{1'b1, OP_ADD, 1'b1, 4'd2, K_NONE};
      tbl[4]  = '{1'b1, OP_ADD, 1'b1, 4'd7, K_EXE};
      tbl[5]  = '{1'b1, OP_ADD, 1'b1, 4'd8, K_WBA};
      tbl[6]  = '{1'b1, OP_CB,  1'b1, 4'd1, K_FR};
      tbl[7]  = '{1'b1, OP_CB,  1'b1, 4'd2, K_R2L};
      tbl[8]  = '{1'b1, OP_CB,  1'b1, 4'd9, K_BR};
      tbl[9]  = '{1'b1, OP_ST,  1'b1, 4'd1, K_FR};
      tbl[10] = '{1'b1, OP_ST,  1'b1, 4'd2, K_R2L};
      tbl[11] = '{1'b1, OP_ST,  1'b1, 4'd3, K_MAS};
      tbl[12] = '{1'b1, OP_ST,  1'b1, 4'd6, K_MWR};
      tbl[13] = '{1'b1, OP_LD,  1'b1, 4'd1, K_FR};
      tbl[14] = '{1'b1, OP_LD,  1'b1, 4'd2, K_NONE};
      tbl[15] = '{1'b1, OP_LD,  1'b1, 4'd3, K_MAL};
      tbl[16] = '{1'b1, OP_LD,  1'b1, 4'd4, K_MRD};
      tbl[17] = '{1'b1, OP_LD,  1'b1, 4'd5, K_WBM};
      tbl[18] = '{1'b1, OP_SUB, 1'b0, 4'd1, K_FW};
      tbl[19] = '{1'b1, OP_SUB, 1'b1, 4'd1, K_FR};
      tbl[20] = '{1'b1, OP_SUB, 1'b1, 4'd2, K_NONE};
      tbl[21] = '{1'b1, OP_SUB, 1'b1, 4'd7, K_EXE};

      for (int i = 0; i < 22; i++) begin
         step(tbl[i].rn, tbl[i].op, tbl[i].rdy);
         check($sformatf("vec%0d", i),
               {14'd0, bus.illegal_op, bus.bus_err, bus.state, act_ctl},
               {14'd0, 2'b00, tbl[i].st, tbl[i].ctl});
      end

      // LDUR with three wait cycles in MEM_RD
      do_reset();
      step(1'b1, OP_LD, 1'b1);
      step(1'b1, OP_LD, 1'b1);
      step(1'b1, OP_LD, 1'b1);
      step(1'b1, OP_LD, 1'b1);
      check("ld_addr", 32'(bus.state), 32'd3);
      for (int k = 0; k < 4; k++) begin
         step(1'b1, OP_LD, k == 3);
         check($sformatf("ld_wait%0d", k),
               {27'd0, bus.MemRead, bus.state}, {27'd0, 1'b1, 4'd4});
      end
      step(1'b1, OP_LD, 1'b0);
      check("ld_wb", {26'd0, bus.MemtoReg, bus.RegWrite, bus.state},
            {26'd0, 2'b11, 4'd5});

      // FETCH timeout: 16 cycles waiting, then IDLE with bus_err pulse
      do_reset();
      step(1'b1, OP_ADD, 1'b0);
      for (int k = 0; k < 16; k++) begin
         step(1'b1, OP_ADD, 1'b0);
         check($sformatf("to_fetch%0d", k), 32'(bus.state), 32'd1);
      end
      step(1'b1, OP_ADD, 1'b0);
      check("to_idle", {27'd0, bus.bus_err, bus.state}, {27'd0, 1'b1, 4'd0});
      step(1'b1, OP_ADD, 1'b0);
      check("to_after", {27'd0, bus.bus_err, bus.state}, {27'd0, 1'b0, 4'd1});

      // Ready on the expiry cycle wins
      do_reset();
      step(1'b1, OP_ADD, 1'b0);
      for (int k = 0; k < 16; k++) step(1'b1, OP_ADD, k == 15);
      check("late_rdy_fetch", 32'(bus.state), 32'd1);
      step(1'b1, OP_ADD, 1'b0);
      check("late_rdy_dec", {27'd0, bus.bus_err, bus.state},
            {27'd0, 1'b0, 4'd2});
      step(1'b1, OP_ADD, 1'b0);
      check("late_rdy_noerr", {27'd0, bus.bus_err, bus.state},
            {27'd0, 1'b0, 4'd7});

      // Illegal opcode
      do_reset();
      step(1'b1, OP_BAD, 1'b1);
      step(1'b1, OP_BAD, 1'b1);
      step(1'b1, OP_BAD, 1'b1);
      check("ill_dec", {27'd0, bus.illegal_op, bus.state},
            {27'd0, 1'b0, 4'd2});
      step(1'b1, OP_BAD, 1'b1);
`ifdef MULTICYCLE_TRAP_EN
      check("ill_trap", {27'd0, bus.illegal_op, bus.state},
            {27'd0, 1'b1, 4'd10});
      step(1'b1, OP_BAD, 1'b1);
      check("ill_trap_hold", {15'd0, bus.illegal_op, bus.state, act_ctl},
            {15'd0, 1'b1, 4'd10, K_NONE});
`else
      check("ill_nop", {27'd0, bus.illegal_op, bus.state},
            {27'd0, 1'b1, 4'd1});
      step(1'b1, OP_ADD, 1'b1);
      check("ill_sticky", {27'd0, bus.illegal_op, bus.state},
            {27'd0, 1'b1, 4'd2});
`endif

      // Reset pulse during MEM_WR
      do_reset();
      step(1'b1, OP_ST, 1'b1);
      step(1'b1, OP_ST, 1'b1);
`ifndef MULTICYCLE_TRAP_EN
      step(1'b1, OP_BAD, 1'b1);
      step(1'b1, OP_ST, 1'b1);
      check("wr_ill_set", 32'(bus.illegal_op), 32'd1);
`endif
      step(1'b1, OP_ST, 1'b1);
      step(1'b1, OP_ST, 1'b0);
      step(1'b1, OP_ST, 1'b0);
      check("wr_state", {15'd0, bus.state, act_ctl}, {15'd0, 4'd6, K_MWR});
      #2;
      reset_n = 1'b0;
      #1;
      check("wr_abort", {26'd0, bus.mem_req, bus.MemWrite, bus.state},
            {26'd0, 2'b00, 4'd0});
      check("wr_ill_clr", 32'(bus.illegal_op), 32'd0);
      step(1'b1, OP_ADD, 1'b1);
      check("wr_restart0", 32'(bus.state), 32'd0);
      step(1'b1, OP_ADD, 1'b1);
      check("wr_restart1", 32'(bus.state), 32'd1);

      // Randomized run against the instruction-level model
      do_reset();
      m_st = 0;
      m_cls = 4;
      m_wait = 0;
      m_ill = 1'b0;
      m_err = 1'b0;
      plan.delete();
      stall = 0;
      cur_op = OP_ADD;
      for (int i = 0; i < 3000; i++) begin
         if (m_st == 0 || m_st == 1) begin
            case ($urandom_range(0, 7))
               0: cur_op = OP_LD;
               1: cur_op = OP_ST;
               2: cur_op = {8'b1011_0100, 3'($urandom_range(0, 7))};
               3: cur_op = OP_ADD;
               4: cur_op = OP_SUB;
               5: cur_op = OP_AND;
               6: cur_op = OP_ORR;
`ifdef MULTICYCLE_TRAP_EN
               default: cur_op = OP_ADD;
`else
               default: cur_op = 11'($urandom);
`endif
            endcase
         end
         if (stall > 0) begin
            rdy = 1'b0;
            stall--;
         end else begin
            if ($urandom_range(0, 149) == 0) stall = 18;
            rdy = ($urandom_range(0, 2) != 0);
         end
         step(1'b1, cur_op, rdy);
         check($sformatf("rnd%0d", i),
               {14'd0, bus.illegal_op, bus.bus_err, bus.state, act_ctl},
               {14'd0, m_ill, m_err, 4'(m_st),
                exp_ctl(m_st, rdy, cur_op, m_cls)});

         nerr = 1'b0;
         nst = m_st;
         case (m_st)
            0: nst = 1;
            1, 4, 6: begin
               if (rdy) begin
                  if (m_st == 1) nst = 2;
                  else nst = (plan.size() > 0) ? plan.pop_front() : 1;
               end else if (T != 0 && m_wait == T) begin
                  nst = 0;
                  nerr = 1'b1;
                  plan.delete();
               end
            end
            2: begin
               m_cls = cls_of(cur_op);
               case (m_cls)
                  0: plan = '{3, 4, 5};
                  1: plan = '{3, 6};
                  2: plan = '{9};
                  3: plan = '{7, 8};
                  default: begin
                     m_ill = 1'b1;
`ifdef MULTICYCLE_TRAP_EN
                     plan = '{10};
`else
                     plan.delete();
`endif
                  end
               endcase
               nst = (plan.size() > 0) ? plan.pop_front() : 1;
            end
            10: nst = 10;
            default: nst = (plan.size() > 0) ? plan.pop_front() : 1;
         endcase
         if (nst != m_st) m_wait = 0;
         else if ((m_st == 1 || m_st == 4 || m_st == 6) && !rdy) m_wait++;
         m_st = nst;
         m_err = nerr;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
